// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with a small transmit FIFO in front of it. Bytes are
// queued with TxD_start whenever ready is high. Each byte is then sent as a
// frame: a start bit (0), DATA_BITS data bits LSB first, an optional parity
// bit and STOP_BITS stop bits (1). The bit rate comes from the external
// uart_tick pulse, and every line change happens on a tick edge. When more
// data is queued, frames follow each other with no idle bits in between.
//
// Parameters:
//   DATA_BITS  : data bits per frame, 5..9
//   PARITY     : 0 = none, 1 = even, 2 = odd
//   STOP_BITS  : stop bits per frame, 1 or 2
//   FIFO_DEPTH : FIFO entries, a power of two in 2..64
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high reset
//   uart_tick  : one-cycle baud pulse; one bit time per tick interval
//   TxD_data   : byte to enqueue
//   TxD_start  : enqueue strobe, accepted only while ready is high
//   ready      : FIFO not full
//   overflow   : one-cycle pulse after a strobe that arrived while full
//   busy       : a frame bit is currently on the line
//   fifo_count : entries queued, not counting the frame being shifted out
//   TxD        : registered serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              uart_tick,
   input  logic [DATA_BITS-1:0]              TxD_data,
   input  logic                              TxD_start,
   output logic                              ready,
   output logic                              overflow,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              TxD
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   // Reject parameter combinations the datapath cannot handle, at
   // elaboration time.
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   state_t               state;
   logic [DATA_BITS-1:0] shifter;
   logic                 parity_bit;
   logic [3:0]           bit_cnt;

   logic [DATA_BITS-1:0] head;
   logic                 head_parity;
   logic                 have_data;
   logic                 last_stop;
   logic                 wr_en;
   logic                 pop;

   // ready comes straight from the registered count, so a pop in the same
   // cycle never opens a slot for a write while the FIFO is full.
   assign fifo_count  = count;
   assign ready       = (count < CNT_W'(FIFO_DEPTH));
   assign have_data   = (count != '0);
   assign head        = mem[rd_ptr];
   assign head_parity = (^head) ^ (PARITY == 2);
   assign last_stop   = (state == ST_STOP) && (bit_cnt == 4'(STOP_BITS - 1));
   assign wr_en       = TxD_start && ready && !reset;

   // The head is popped on the tick that starts a frame, either from idle
   // or straight after the last stop bit of the previous frame.
   assign pop = uart_tick && have_data && !reset &&
                ((state == ST_IDLE) || last_stop);

   // FIFO storage is not reset; count and pointers define which entries
   // are valid.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr] <= TxD_data;
      end
   end

   // Pointer and occupancy bookkeeping. The pointers are exactly PTR_W bits
   // wide, so they wrap modulo FIFO_DEPTH on their own. A write and a pop in
   // the same cycle cancel out in the count. overflow is registered: it
   // pulses on the cycle after a rejected strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         overflow <= TxD_start && !ready;
      end
   end

   // Frame sequencer. Everything advances only on uart_tick, so each bit
   // holds for exactly one tick interval. TxD and busy are updated on the
   // same edge as the state, which keeps the line glitch-free. The shifter
   // moves one place per data bit, so TxD always takes the next LSB. Parity
   // is computed when the byte is popped and is then held until needed.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         TxD        <= 1'b1;
         busy       <= 1'b0;
         bit_cnt    <= '0;
         shifter    <= '0;
         parity_bit <= 1'b0;
      end else if (uart_tick) begin
         case (state)
            ST_IDLE: begin
               if (have_data) begin
                  state      <= ST_START;
                  shifter    <= head;
                  parity_bit <= head_parity;
                  TxD        <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            ST_START: begin
               state   <= ST_DATA;
               bit_cnt <= '0;
               TxD     <= shifter[0];
            end
            ST_DATA: begin
               if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
                  if (PARITY != 0) begin
                     state <= ST_PARITY;
                     TxD   <= parity_bit;
                  end else begin
                     state <= ST_STOP;
                     TxD   <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                  shifter <= shifter >> 1;
                  TxD     <= shifter[1];
               end
            end
            ST_PARITY: begin
               state   <= ST_STOP;
               bit_cnt <= '0;
               TxD     <= 1'b1;
            end
            ST_STOP: begin
               if (last_stop) begin
                  bit_cnt <= '0;
                  if (have_data) begin
                     state      <= ST_START;
                     shifter    <= head;
                     parity_bit <= head_parity;
                     TxD        <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     TxD   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               TxD   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
